// File: rtl/enc_bundler_if.sv
// Handshake bundle between the binder pack, the bundler and the downstream
// classifier stage: beat input, frame control and encoded result.
interface enc_bundler_if #(
  parameter int HV_DIM = 1024,
  parameter int LANES  = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [HV_DIM-1:0] shifted_hv [LANES];
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [HV_DIM-1:0] encoded_hv;

  modport master (
    output start, in_valid, shifted_hv, out_ready,
    input  in_ready, busy, out_valid, encoded_hv
  );

  modport slave (
    input  start, in_valid, shifted_hv, out_ready,
    output in_ready, busy, out_valid, encoded_hv
  );
endinterface

// File: rtl/enc_bundler.sv
// Bundles NUM_BEATS beats of LANES shifted hypervectors into per-dimension
// popcounts and thresholds them into one encoded hypervector per frame.
module enc_bundler #(
  parameter int HV_DIM    = 1024,
  parameter int LANES     = 8,
  parameter int NUM_BEATS = 4,
  parameter int THRESHOLD = 2,
  localparam int CNT_W    = $clog2(LANES * NUM_BEATS + 1)
) (
  input logic        clk,
  input logic        rst,
  enc_bundler_if.slave bus
);

  localparam int BEAT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    THRESH = 2'd2,
    OUT    = 2'd3
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q [HV_DIM];
  logic [CNT_W-1:0]  lane_sum_s [HV_DIM];
  logic [BEAT_W-1:0] beat_q;
  logic [HV_DIM-1:0] enc_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              out_valid_q;

  // Per-dimension count of set bits across all lanes of the current beat
  always_comb begin
    for (int d = 0; d < HV_DIM; d++) begin
      lane_sum_s[d] = '0;
      for (int l = 0; l < LANES; l++) begin
        lane_sum_s[d] = lane_sum_s[d] + CNT_W'(bus.shifted_hv[l][d]);
      end
    end
  end

  // Frame FSM with accumulators and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      enc_q       <= '0;
      beat_q      <= '0;
      for (int d = 0; d < HV_DIM; d++) cnt_q[d] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= ACCUM;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            beat_q     <= '0;
            for (int d = 0; d < HV_DIM; d++) cnt_q[d] <= '0;
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            for (int d = 0; d < HV_DIM; d++) cnt_q[d] <= cnt_q[d] + lane_sum_s[d];
            beat_q <= beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(NUM_BEATS - 1)) begin
              state_q    <= THRESH;
              in_ready_q <= 1'b0;
            end
          end
        end
        THRESH: begin
          for (int d = 0; d < HV_DIM; d++) enc_q[d] <= (cnt_q[d] >= CNT_W'(THRESHOLD));
          state_q     <= OUT;
          out_valid_q <= 1'b1;
        end
        OUT: begin
          // encoded result stays put until the consumer takes it
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.encoded_hv = enc_q;

endmodule
